// File: rtl/lbp_host_mem.sv
// Host-side memory responder for the LBP engine: loads the gray image, serves
// zero-latency pixel reads, captures LBP results and streams the result image out.
module lbp_host_mem #(
  parameter int unsigned IMG_W  = 128,
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              gray_ready,
  input  logic              gray_req,
  input  logic [ADDR_W-1:0] gray_addr,
  output logic [DATA_W-1:0] gray_data,
  input  logic              lbp_valid,
  input  logic [ADDR_W-1:0] lbp_addr,
  input  logic [DATA_W-1:0] lbp_data,
  input  logic              finish,
  output logic              dump_valid,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  input  logic              dump_ready,
  output logic              done,
  output logic              err
);

  localparam int unsigned COL_W = $clog2(IMG_W);
  localparam int unsigned ROW_W = ADDR_W - COL_W;
  localparam int unsigned DEPTH = IMG_W * IMG_W;

  typedef enum logic [1:0] {LOAD, SERVE, DUMP, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] ld_cnt;
  logic [ADDR_W-1:0] dp_cnt;
  logic [DATA_W-1:0] gray_mem [0:DEPTH-1];
  logic [DATA_W-1:0] res_mem  [0:DEPTH-1];

  logic load_acc;
  logic lbp_wr;
  logic viol;

  function automatic logic is_border(input logic [ADDR_W-1:0] a);
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    row = a[ADDR_W-1:COL_W];
    col = a[COL_W-1:0];
    return (row == '0) || (row == ROW_W'(IMG_W - 1)) ||
           (col == '0) || (col == COL_W'(IMG_W - 1));
  endfunction

  // Border results are never stored, so a border write is treated as a violation and dropped.
  always_comb begin
    load_acc = (state == LOAD) && load_valid;
    lbp_wr   = (state == SERVE) && lbp_valid && !is_border(lbp_addr);
    viol     = (lbp_valid && ((state != SERVE) || is_border(lbp_addr))) ||
               (gray_req && (state != SERVE)) ||
               (load_valid && (state == SERVE));
  end

  always_ff @(posedge clk) begin
    if (load_acc) gray_mem[ld_cnt] <= load_data;
    if (lbp_wr)   res_mem[lbp_addr] <= lbp_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= LOAD;
      ld_cnt     <= '0;
      dp_cnt     <= '0;
      err        <= 1'b0;
      load_ready <= 1'b1;
      gray_ready <= 1'b0;
      dump_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      if (viol) err <= 1'b1;
      case (state)
        LOAD: begin
          if (load_valid) begin
            ld_cnt <= ld_cnt + ADDR_W'(1);
            if (ld_cnt == '1) begin
              state      <= SERVE;
              load_ready <= 1'b0;
              gray_ready <= 1'b1;
            end
          end
        end
        SERVE: begin
          if (finish) begin
            state      <= DUMP;
            gray_ready <= 1'b0;
            dump_valid <= 1'b1;
          end
        end
        DUMP: begin
          if (dump_ready) begin
            dp_cnt <= dp_cnt + ADDR_W'(1);
            if (dp_cnt == '1) begin
              state      <= DONE;
              dump_valid <= 1'b0;
              done       <= 1'b1;
            end
          end
        end
        DONE: ;
        default: state <= LOAD;
      endcase
    end
  end

  // dp_cnt wraps to 0 on the final handshake, so dump_addr reads 0 outside DUMP.
  assign dump_addr = dp_cnt;

  always_comb begin
    gray_data = '0;
    if (gray_ready && gray_req) gray_data = gray_mem[gray_addr];
    dump_data = '0;
    if (dump_valid && !is_border(dp_cnt)) dump_data = res_mem[dp_cnt];
  end

endmodule

// File: tb/tb_lbp_host_mem.sv
// Bench for lbp_host_mem: random image and result codes checked against array
// models of the gray image and the result buffer.
module tb_lbp_host_mem;

  localparam int N = 16384;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_valid;
  logic [7:0]  load_data;
  logic        load_ready;
  logic        gray_ready;
  logic        gray_req;
  logic [13:0] gray_addr;
  logic [7:0]  gray_data;
  logic        lbp_valid;
  logic [13:0] lbp_addr;
  logic [7:0]  lbp_data;
  logic        finish;
  logic        dump_valid;
  logic [13:0] dump_addr;
  logic [7:0]  dump_data;
  logic        dump_ready;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;
  logic [7:0] gray_model [N];
  logic [7:0] res_model  [N];

  lbp_host_mem #(.IMG_W(128), .ADDR_W(14), .DATA_W(8)) dut (
    .clk(clk), .reset(reset),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .gray_ready(gray_ready), .gray_req(gray_req), .gray_addr(gray_addr), .gray_data(gray_data),
    .lbp_valid(lbp_valid), .lbp_addr(lbp_addr), .lbp_data(lbp_data), .finish(finish),
    .dump_valid(dump_valid), .dump_addr(dump_addr), .dump_data(dump_data), .dump_ready(dump_ready),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic bit border(input int a);
    int r, c;
    r = a / 128;
    c = a % 128;
    return (r == 0) || (r == 127) || (c == 0) || (c == 127);
  endfunction

  task automatic load_image(input int beats);
    for (int i = 0; i < beats; i++) begin
      while ($urandom_range(7) == 0) begin
        load_valid = 1'b0;
        tick();
      end
      load_valid    = 1'b1;
      load_data     = 8'($urandom);
      gray_model[i] = load_data;
      if (i == N - 1) begin
        #1;
        check("ready_before_last", {30'd0, gray_ready, load_ready}, 32'd1);
      end
      tick();
    end
    load_valid = 1'b0;
  endtask

  initial begin
    int  k;
    int  cyc;
    bit  toggled;
    bit  rdy;
    reset = 1'b1; load_valid = 1'b0; load_data = '0; gray_req = 1'b0; gray_addr = '0;
    lbp_valid = 1'b0; lbp_addr = '0; lbp_data = '0; finish = 1'b0; dump_ready = 1'b0;
    foreach (res_model[i]) res_model[i] = '0;
    #2;
    check("rst_load_ready", load_ready, 1);
    check("rst_gray_ready", gray_ready, 0);
    check("rst_gray_data",  gray_data, 0);
    check("rst_dump_valid", dump_valid, 0);
    check("rst_dump_addr",  dump_addr, 0);
    check("rst_dump_data",  dump_data, 0);
    check("rst_done",       done, 0);
    check("rst_err",        err, 0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // Read while loading: returns 0 and flags err
    gray_req = 1'b1; gray_addr = 14'd5;
    #1;
    check("read_in_load", gray_data, 0);
    check("err_before", err, 0);
    tick();
    gray_req = 1'b0;
    check("err_read_in_load", err, 1);

    // Partial load then asynchronous reset
    load_image(8000);
    reset = 1'b1;
    #1;
    check("midload_rst_load_ready", load_ready, 1);
    check("midload_rst_gray_ready", gray_ready, 0);
    check("midload_rst_err", err, 0);
    tick();
    reset = 1'b0;
    tick();

    load_image(N);
    check("serve_gray_ready", gray_ready, 1);
    check("serve_load_ready", load_ready, 0);

    gray_req = 1'b1; gray_addr = 14'd129;
    #1;
    check("read_129", gray_data, gray_model[129]);
    gray_req = 1'b0;
    #1;
    check("read_noreq", gray_data, 0);
    tick();

    // Engine writes every interior result while issuing random reads
    for (int a = 0; a < N; a++) begin
      if (border(a)) continue;
      lbp_valid    = 1'b1;
      lbp_addr     = 14'(a);
      lbp_data     = 8'($urandom);
      res_model[a] = lbp_data;
      gray_req     = 1'($urandom_range(1));
      gray_addr    = 14'($urandom);
      #1;
      check("serve_read", gray_data, gray_req ? gray_model[gray_addr] : 8'd0);
      tick();
    end
    lbp_valid = 1'b0; gray_req = 1'b0;
    check("err_clean_serve", err, 0);

    // Violations: border write, then load beat in SERVE
    lbp_valid = 1'b1; lbp_addr = 14'd0; lbp_data = 8'h55;
    tick();
    lbp_valid = 1'b0;
    check("err_border_write", err, 1);
    load_valid = 1'b1; load_data = ~gray_model[0];
    tick();
    load_valid = 1'b0;
    check("err_sticky", err, 1);
    gray_req = 1'b1; gray_addr = 14'd0;
    #1;
    check("image_unchanged_0", gray_data, gray_model[0]);
    gray_addr = 14'd1;
    #1;
    check("image_unchanged_1", gray_data, gray_model[1]);
    gray_req = 1'b0;
    tick();

    // Write in the finish cycle is committed
    finish = 1'b1; lbp_valid = 1'b1; lbp_addr = 14'd16254; lbp_data = 8'h3C;
    res_model[16254] = 8'h3C;
    #1;
    check("dump_valid_pre", dump_valid, 0);
    tick();
    lbp_valid = 1'b0;
    check("first_dump_valid", dump_valid, 1);
    check("first_dump_addr", dump_addr, 0);
    check("dump_gray_ready", gray_ready, 0);

    k = 0; cyc = 0; toggled = 1'b0;
    while (k < N && cyc < 40000) begin
      if (k == 5 && !toggled) begin
        rdy = 1'b0;
        toggled = 1'b1;
      end else begin
        rdy = ($urandom_range(7) != 0);
      end
      dump_ready = rdy;
      #1;
      check("dump_valid", dump_valid, 1);
      check("dump_addr", dump_addr, k);
      check("dump_data", dump_data, border(k) ? 8'd0 : res_model[k]);
      if (k == N - 1) check("done_early", done, 0);
      if (rdy) k++;
      cyc++;
      tick();
    end
    dump_ready = 1'b0;
    check("dump_beats", k, N);
    check("done_rise", done, 1);
    check("done_dump_valid", dump_valid, 0);
    check("done_load_ready", load_ready, 0);
    check("done_gray_ready", gray_ready, 0);
    check("done_dump_data", dump_data, 0);
    tick(); tick(); tick();
    check("done_hold", done, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
